// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master core among NUM_REQ requesters.
// Latches the winner's descriptor at grant and returns MISO data or a start-timeout error.
module spi_req_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int START_TO = 64,
    parameter int IDX_W    = 1
) (
    input  logic                   GCLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [2*NUM_REQ-1:0]   req_mode_i,
    input  logic [2*NUM_REQ-1:0]   req_speed_i,
    input  logic [2*NUM_REQ-1:0]   req_len_i,
    input  logic [32*NUM_REQ-1:0]  req_mosi_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic                   rsp_err_o,
    output logic [31:0]            rsp_data_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   spi_start_o,
    input  logic                   spi_busy_i,
    output logic [1:0]             spi_mode_o,
    output logic [1:0]             spi_speed_o,
    output logic [1:0]             spi_len_o,
    output logic [31:0]            spi_mosi_o,
    input  logic [31:0]            spi_miso_i
);

    localparam int CNT_W = $clog2(START_TO) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP,
        S_ERR
    } state_t;

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_owner, r_ptr, w_pick;
    logic [IDX_W:0]     w_sum;
    logic               w_found, w_grant_en, w_timeout;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0] w_rot, r_grant;
    logic [1:0]         w_mode, w_speed, w_len, r_mode, r_speed, r_len;
    logic [31:0]        w_mosi, r_mosi, r_rsp_data;
    logic [CNT_W-1:0]   r_cnt;

    // Rotate valids so bit 0 is the current pointer, then map the first hit back.
    always_comb begin
        w_dbl   = {req_valid_i, req_valid_i};
        w_rot   = NUM_REQ'(w_dbl >> r_ptr);
        w_found = 1'b0;
        w_sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (IDX_W+1)'(i);
            end
        end
        if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
        end
        w_pick = w_sum[IDX_W-1:0];
    end

    always_comb begin
        w_mode  = '0;
        w_speed = '0;
        w_len   = '0;
        w_mosi  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_pick == IDX_W'(j)) begin
                w_mode  = req_mode_i[2*j +: 2];
                w_speed = req_speed_i[2*j +: 2];
                w_len   = req_len_i[2*j +: 2];
                w_mosi  = req_mosi_i[32*j +: 32];
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(START_TO - 1));

    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant_en  = 1'b0;
        spi_start_o = 1'b0;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_err_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!spi_busy_i && w_found) begin
                    w_grant_en = 1'b1;
                    w_next     = S_START;
                end
            end
            S_START: begin
                spi_start_o = 1'b1;
                req_ready_o = r_grant;
                w_next      = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (spi_busy_i) begin
                    w_next = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WAIT_DONE: begin
                if (!spi_busy_i) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = r_grant;
                w_next      = S_IDLE;
            end
            S_ERR: begin
                rsp_valid_o = r_grant;
                rsp_err_o   = 1'b1;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            r_owner    <= '0;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_mode     <= '0;
            r_speed    <= '0;
            r_len      <= '0;
            r_mosi     <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_grant_en) begin
                r_owner <= w_pick;
                r_grant <= NUM_REQ'(1) << w_pick;
                r_mode  <= w_mode;
                r_speed <= w_speed;
                r_len   <= w_len;
                r_mosi  <= w_mosi;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY && !spi_busy_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Error responses carry zero data, so clear on the way into ERR.
            if (r_state == S_WAIT_DONE && !spi_busy_i) begin
                r_rsp_data <= spi_miso_i;
            end else if (r_state == S_WAIT_BUSY && !spi_busy_i && w_timeout) begin
                r_rsp_data <= '0;
            end
            if (r_state == S_RESP || r_state == S_ERR) begin
                r_grant <= '0;
                r_ptr   <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
            end
        end
    end

    assign grant_o     = r_grant;
    assign rsp_data_o  = r_rsp_data;
    assign spi_mode_o  = r_mode;
    assign spi_speed_o = r_speed;
    assign spi_len_o   = r_len;
    assign spi_mosi_o  = r_mosi;

endmodule
